// File: rtl/mem_controller.sv
// Data-memory responder for the APCPU ALU bus: latches a request, waits a fixed
// number of cycles, then performs the RAM access and pulses ValidMemData.
module mem_controller #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [1:0]  MemIO,
    input  logic [31:0] ALUAddr,
    input  logic [31:0] DataWr,
    output logic [31:0] DataRd,
    output logic        ValidMemData,
    output logic        MemErr,
    output logic        MemBusy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int          DEPTH = 1 << ADDR_W;
    localparam logic [3:0]  WS    = 4'(WAIT_STATES);

    localparam logic [1:0]  CODE_NOP   = 2'b00;
    localparam logic [1:0]  CODE_READ  = 2'b01;
    localparam logic [1:0]  CODE_WRITE = 2'b10;
    localparam logic [1:0]  CODE_RSVD  = 2'b11;

    // Reserved codes and any address bit above the RAM range reject the request.
    function automatic logic req_err(input logic [1:0] code, input logic [31:0] addr);
        logic w_hi;
        w_hi = |(addr >> ADDR_W);
        return (code == CODE_RSVD) || w_hi;
    endfunction

    logic [31:0] r_mem [DEPTH];

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic [1:0]  r_code;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [31:0] r_rd;
    logic        r_valid;
    logic        r_err;
    logic        r_busy;

    logic        w_accept;
    logic [1:0]  w_code;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic        w_err;
    logic        w_enter_done;
    logic        w_do_write;
    logic        w_do_read;

    // With zero wait states the access happens on the accept edge, so use the live bus.
    always_comb begin
        w_accept = (r_state == S_IDLE) && (MemIO != CODE_NOP);
        if (r_state == S_IDLE) begin
            w_code = MemIO;
            w_addr = ALUAddr;
            w_data = DataWr;
        end else begin
            w_code = r_code;
            w_addr = r_addr;
            w_data = r_data;
        end
        w_err        = req_err(w_code, w_addr);
        w_enter_done = (w_next == S_DONE);
        w_do_write   = w_enter_done && !w_err && (w_code == CODE_WRITE);
        w_do_read    = w_enter_done && !w_err && (w_code == CODE_READ);
    end

    // Next-state and wait-counter logic.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (MemIO != CODE_NOP) begin
                    w_cnt_next = WS;
                    if (WS != 4'd0) begin
                        w_next = S_WAIT;
                    end else begin
                        w_next = S_DONE;
                    end
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_WAIT: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next     = S_IDLE;
                w_cnt_next = 4'd0;
            end
        endcase
    end

    // State, counter and request latch.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_code  <= 2'b00;
            r_addr  <= 32'd0;
            r_data  <= 32'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_code <= MemIO;
                r_addr <= ALUAddr;
                r_data <= DataWr;
            end
        end
    end

    // Registered handshake outputs; they reflect the state being entered.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_rd    <= 32'd0;
        end else begin
            r_valid <= w_enter_done;
            r_err   <= w_enter_done && w_err;
            r_busy  <= (w_next != S_IDLE);
            if (w_do_read) begin
                r_rd <= r_mem[w_addr[ADDR_W-1:0]];
            end
        end
    end

    // RAM write port; contents are deliberately not reset, and reset blocks any write.
    always_ff @(posedge CLK) begin
        if (w_do_write && RST_N) begin
            r_mem[w_addr[ADDR_W-1:0]] <= w_data;
        end
    end

    assign DataRd       = r_rd;
    assign ValidMemData = r_valid;
    assign MemErr       = r_err;
    assign MemBusy      = r_busy;

endmodule

// File: tb/tb_mem_controller.sv
// Directed bench for mem_controller: one instance with two wait states, one with none.
module tb_mem_controller;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [1:0]  mio_a, mio_b;
    logic [31:0] addr_a, addr_b, wd_a, wd_b, rd_a, rd_b;
    logic        vld_a, vld_b, err_a, err_b, busy_a, busy_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_controller #(.ADDR_W(10), .WAIT_STATES(2)) u_dut (
        .CLK(clk), .RST_N(rst_n), .MemIO(mio_a), .ALUAddr(addr_a), .DataWr(wd_a),
        .DataRd(rd_a), .ValidMemData(vld_a), .MemErr(err_a), .MemBusy(busy_a)
    );

    mem_controller #(.ADDR_W(10), .WAIT_STATES(0)) u_dut0 (
        .CLK(clk), .RST_N(rst_n), .MemIO(mio_b), .ALUAddr(addr_b), .DataWr(wd_b),
        .DataRd(rd_b), .ValidMemData(vld_b), .MemErr(err_b), .MemBusy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic [1:0] code, input logic [31:0] addr,
                         input logic [31:0] data);
        if (sel) begin
            mio_b = code; addr_b = addr; wd_b = data;
        end else begin
            mio_a = code; addr_a = addr; wd_a = data;
        end
    endtask

    task automatic obs(input bit sel, output logic v, output logic e, output logic b,
                       output logic [31:0] rd);
        if (sel) begin
            v = vld_b; e = err_b; b = busy_b; rd = rd_b;
        end else begin
            v = vld_a; e = err_a; b = busy_a; rd = rd_a;
        end
    endtask

    // One request: accept edge, wait states, completion cycle, then one ignored cycle.
    // n_* is driven on the bus after acceptance and must have no effect.
    task automatic req(input bit sel, input string tag, input logic [1:0] code,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic exp_err, input logic [31:0] exp_rd,
                       input logic [1:0] n_code, input logic [31:0] n_addr,
                       input logic [31:0] n_data);
        int          ws;
        logic        v, e, b;
        logic [31:0] rd;
        ws = sel ? 0 : 2;
        drive(sel, code, addr, data);
        tick();
        drive(sel, n_code, n_addr, n_data);
        for (int k = 0; k <= ws; k++) begin
            if (k > 0) tick();
            obs(sel, v, e, b, rd);
            check({tag, "_busy"}, 32'(b), 32'd1);
            if (k < ws) check({tag, "_early"}, {30'd0, v, e}, 32'd0);
        end
        check({tag, "_valid"}, 32'(v), 32'd1);
        check({tag, "_err"}, 32'(e), 32'(exp_err));
        check({tag, "_rd"}, rd, exp_rd);
        tick();
        obs(sel, v, e, b, rd);
        check({tag, "_after"}, {29'd0, v, e, b}, 32'd0);
        drive(sel, 2'b00, 32'd0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        v, e, b;
        logic [31:0] rd;

        rst_n = 1'b0;
        drive(1'b0, 2'b00, 32'd0, 32'd0);
        drive(1'b1, 2'b00, 32'd0, 32'd0);
        repeat (3) tick();
        for (int s = 0; s < 2; s++) begin
            obs(s[0], v, e, b, rd);
            check("rst_flags", {29'd0, v, e, b}, 32'd0);
            check("rst_rd", rd, 32'd0);
        end
        rst_n = 1'b1;

        // Zero wait states: completion on the accept edge, accepts two cycles apart.
        req(1'b1, "ws0_wr", 2'b10, 32'd0, 32'hCAFE_F00D, 1'b0, 32'd0,
            2'b10, 32'd0, 32'h0BAD_F00D);
        req(1'b1, "ws0_rd", 2'b01, 32'd0, 32'd0, 1'b0, 32'hCAFE_F00D,
            2'b00, 32'd0, 32'd0);
        req(1'b1, "ws0_rsvd", 2'b11, 32'd0, 32'd0, 1'b1, 32'hCAFE_F00D,
            2'b00, 32'd0, 32'd0);

        // Two wait states.
        req(1'b0, "wr5", 2'b10, 32'd5, 32'hDEAD_BEEF, 1'b0, 32'd0, 2'b00, 32'd0, 32'd0);
        req(1'b0, "rd5", 2'b01, 32'd5, 32'd0, 1'b0, 32'hDEAD_BEEF, 2'b00, 32'd0, 32'd0);
        req(1'b0, "wr1", 2'b10, 32'd1, 32'h1111_1111, 1'b0, 32'hDEAD_BEEF, 2'b00, 32'd0, 32'd0);
        req(1'b0, "wr2", 2'b10, 32'd2, 32'h2222_2222, 1'b0, 32'hDEAD_BEEF, 2'b00, 32'd0, 32'd0);
        req(1'b0, "wr0", 2'b10, 32'd0, 32'h00C0_FFEE, 1'b0, 32'hDEAD_BEEF, 2'b00, 32'd0, 32'd0);
        req(1'b0, "busy_ign", 2'b01, 32'd1, 32'd0, 1'b0, 32'h1111_1111,
            2'b10, 32'd2, 32'hBAD0_BAD0);
        req(1'b0, "rd2", 2'b01, 32'd2, 32'd0, 1'b0, 32'h2222_2222, 2'b00, 32'd0, 32'd0);
        req(1'b0, "rsvd", 2'b11, 32'd1, 32'd0, 1'b1, 32'h2222_2222, 2'b00, 32'd0, 32'd0);
        req(1'b0, "oor_wr", 2'b10, 32'h400, 32'h5555_AAAA, 1'b1, 32'h2222_2222,
            2'b00, 32'd0, 32'd0);
        req(1'b0, "rd0", 2'b01, 32'd0, 32'd0, 1'b0, 32'h00C0_FFEE, 2'b00, 32'd0, 32'd0);
        req(1'b0, "oor_rd", 2'b01, 32'h8000_0005, 32'd0, 1'b1, 32'h00C0_FFEE,
            2'b00, 32'd0, 32'd0);

        for (int i = 0; i < 20; i++) begin
            tick();
            obs(1'b0, v, e, b, rd);
            check("nop_flags", {29'd0, v, e, b}, 32'd0);
            check("nop_rd", rd, 32'h00C0_FFEE);
        end

        // Reset one cycle into a write: the write must be lost and no pulse issued.
        req(1'b0, "wr3", 2'b10, 32'd3, 32'hA5A5_A5A5, 1'b0, 32'h00C0_FFEE, 2'b00, 32'd0, 32'd0);
        drive(1'b0, 2'b10, 32'd3, 32'h1234_5678);
        tick();
        drive(1'b0, 2'b00, 32'd0, 32'd0);
        tick();
        obs(1'b0, v, e, b, rd);
        check("mid_busy", 32'(b), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        obs(1'b0, v, e, b, rd);
        check("arst_flags", {29'd0, v, e, b}, 32'd0);
        check("arst_rd", rd, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            obs(1'b0, v, e, b, rd);
            check("arst_hold", {29'd0, v, e, b}, 32'd0);
        end
        rst_n = 1'b1;
        req(1'b0, "rd3", 2'b01, 32'd3, 32'd0, 1'b0, 32'hA5A5_A5A5, 2'b00, 32'd0, 32'd0);
        req(1'b0, "rd5_post", 2'b01, 32'd5, 32'd0, 1'b0, 32'hDEAD_BEEF, 2'b00, 32'd0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
